// File: rtl/data_array_nway_if.sv
// Request/response bundle between the cache controller (master) and the N-way data array (slave).
// Handshake: a request transfers on a rising clock edge where req_valid & req_ready are both 1;
// req_write/req_addr/req_be/req_wdata are qualified by req_valid. rsp_valid is a one-cycle pulse
// that the consumer cannot stall; rsp_rdata holds its last value while rsp_valid is 0.
interface data_array_nway_if #(
    parameter int WAYS   = 2,
    parameter int LINE_W = 128,
    parameter int DEPTH  = 32
);
    localparam int AW    = $clog2(DEPTH);
    localparam int BE_W  = WAYS * LINE_W / 8;
    localparam int ROW_W = WAYS * LINE_W;

    logic             req_valid;
    logic             req_ready;
    logic             req_write;
    logic [AW-1:0]    req_addr;
    logic [BE_W-1:0]  req_be;
    logic [LINE_W-1:0] req_wdata;
    logic             rsp_valid;
    logic [ROW_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/data_array_nway.sv
// N-way cache data array with clear sequencer, READ_LAT of 1 or 2 and valid-qualified responses.
// Build option DATA_ARRAY_FWD_EN: with READ_LAT==2, merges a same-set write into the pending response.
module data_array_nway #(
    parameter int WAYS     = 2,
    parameter int LINE_W   = 128,
    parameter int DEPTH    = 32,
    parameter int READ_LAT = 1
) (
    input  logic               CK,
    input  logic               RST,
    input  logic               clr_req,
    output logic               init_busy,
    output logic               fsm_state,
    data_array_nway_if.slave   bus
);
    localparam int BYTES = LINE_W / 8;
    localparam int BE_W  = WAYS * BYTES;
    localparam int ROW_W = WAYS * LINE_W;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t           state;
    logic [AW-1:0]    clr_cnt;
    logic [ROW_W-1:0] mem [DEPTH];
    logic [ROW_W-1:0] row;
    logic             accept;
    logic             acc_rd;
    logic             acc_wr;

    function automatic logic [ROW_W-1:0] merge(
        input logic [ROW_W-1:0]  old_row,
        input logic [LINE_W-1:0] wdata,
        input logic [BE_W-1:0]   be
    );
        logic [ROW_W-1:0] r;
        r = old_row;
        for (int w = 0; w < WAYS; w++) begin
            for (int b = 0; b < BYTES; b++) begin
                if (be[w*BYTES + b]) begin
                    r[w*LINE_W + b*8 +: 8] = wdata[b*8 +: 8];
                end
            end
        end
        return r;
    endfunction

    assign accept    = bus.req_valid & bus.req_ready & ~RST;
    assign acc_rd    = accept & ~bus.req_write;
    assign acc_wr    = accept & bus.req_write;
    assign row       = mem[bus.req_addr];
    assign fsm_state = (state == IDLE);

    always_ff @(posedge CK) begin
        if (RST) begin
            state         <= CLEAR;
            clr_cnt       <= '0;
            init_busy     <= 1'b1;
            bus.req_ready <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_req) begin
                        clr_cnt <= '0;
                    end else if (clr_cnt == AW'(DEPTH - 1)) begin
                        state         <= IDLE;
                        clr_cnt       <= '0;
                        init_busy     <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                IDLE: begin
                    // The request presented alongside clr_req is still taken this cycle.
                    if (clr_req) begin
                        state         <= CLEAR;
                        init_busy     <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (acc_wr) begin
            mem[bus.req_addr] <= merge(row, bus.req_wdata, bus.req_be);
        end
    end

    generate
        if (READ_LAT >= 2) begin : g_lat2
            logic             p_valid;
            logic [ROW_W-1:0] p_data;
`ifdef DATA_ARRAY_FWD_EN
            logic [AW-1:0]    p_addr;

            always_ff @(posedge CK) begin
                if (acc_rd) begin
                    p_addr <= bus.req_addr;
                end
            end
`endif

            always_ff @(posedge CK) begin
                if (RST) begin
                    p_valid       <= 1'b0;
                    p_data        <= '0;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                end else begin
                    p_valid       <= acc_rd;
                    bus.rsp_valid <= p_valid;
                    if (acc_rd) begin
                        p_data <= row;
                    end
                    if (p_valid) begin
`ifdef DATA_ARRAY_FWD_EN
                        if (acc_wr && (p_addr == bus.req_addr)) begin
                            bus.rsp_rdata <= merge(p_data, bus.req_wdata, bus.req_be);
                        end else begin
                            bus.rsp_rdata <= p_data;
                        end
`else
                        bus.rsp_rdata <= p_data;
`endif
                    end
                end
            end
        end else begin : g_lat1
            always_ff @(posedge CK) begin
                if (RST) begin
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_rdata <= '0;
                end else begin
                    bus.rsp_valid <= acc_rd;
                    if (acc_rd) begin
                        bus.rsp_rdata <= row;
                    end
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_data_array_nway.sv
// Directed bench for data_array_nway: one READ_LAT=1 and one READ_LAT=2 instance share stimulus,
// and a negedge monitor checks each response's timing and data against expected queues.
module tb_data_array_nway;
    localparam int WAYS   = 2;
    localparam int LINE_W = 128;
    localparam int DEPTH  = 32;
    localparam int AW     = $clog2(DEPTH);
    localparam int BE_W   = WAYS * LINE_W / 8;
    localparam int ROW_W  = WAYS * LINE_W;

    logic CK = 1'b0;
    logic RST = 1'b1;
    logic clr_req = 1'b0;
    logic req_valid = 1'b0;
    logic req_write = 1'b0;
    logic [AW-1:0]     req_addr = '0;
    logic [BE_W-1:0]   req_be = '0;
    logic [LINE_W-1:0] req_wdata = '0;

    logic init_busy1, init_busy2, state1, state2;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [ROW_W-1:0] exp_q1[$];
    logic [ROW_W-1:0] exp_q2[$];
    int               due_q1[$];
    int               due_q2[$];

    logic [ROW_W-1:0] a5_row, old7, new7;
    logic [LINE_W-1:0] new7_line;
    int n1, n2;

    data_array_nway_if #(.WAYS(WAYS), .LINE_W(LINE_W), .DEPTH(DEPTH)) bus1 ();
    data_array_nway_if #(.WAYS(WAYS), .LINE_W(LINE_W), .DEPTH(DEPTH)) bus2 ();

    assign bus1.req_valid = req_valid;
    assign bus1.req_write = req_write;
    assign bus1.req_addr  = req_addr;
    assign bus1.req_be    = req_be;
    assign bus1.req_wdata = req_wdata;
    assign bus2.req_valid = req_valid;
    assign bus2.req_write = req_write;
    assign bus2.req_addr  = req_addr;
    assign bus2.req_be    = req_be;
    assign bus2.req_wdata = req_wdata;

    data_array_nway #(.WAYS(WAYS), .LINE_W(LINE_W), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
        .CK(CK), .RST(RST), .clr_req(clr_req),
        .init_busy(init_busy1), .fsm_state(state1), .bus(bus1)
    );

    data_array_nway #(.WAYS(WAYS), .LINE_W(LINE_W), .DEPTH(DEPTH), .READ_LAT(2)) u_dut2 (
        .CK(CK), .RST(RST), .clr_req(clr_req),
        .init_busy(init_busy2), .fsm_state(state2), .bus(bus2)
    );

    // Clock and cycle count
    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL timeout tests=%0d", tests);
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Scoreboard: rsp_valid must be 1 exactly on the due cycle of the queue head, 0 otherwise.
    always @(negedge CK) begin
        if (mon_en) begin
            logic due;
            due = (due_q1.size() > 0) && (due_q1[0] == cyc);
            check("rsp_valid_lat1", bus1.rsp_valid, due);
            if (due) begin
                check("rsp_rdata_lat1", bus1.rsp_rdata, exp_q1[0]);
                void'(exp_q1.pop_front());
                void'(due_q1.pop_front());
            end
            due = (due_q2.size() > 0) && (due_q2[0] == cyc);
            check("rsp_valid_lat2", bus2.rsp_valid, due);
            if (due) begin
                check("rsp_rdata_lat2", bus2.rsp_rdata, exp_q2[0]);
                void'(exp_q2.pop_front());
                void'(due_q2.pop_front());
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [BE_W-1:0] be,
                            input logic [LINE_W-1:0] wdata);
        check("wr_ready", bus1.req_ready & bus2.req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input logic [ROW_W-1:0] exp1,
                           input logic [ROW_W-1:0] exp2);
        check("rd_ready", bus1.req_ready & bus2.req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = addr;
        exp_q1.push_back(exp1);
        due_q1.push_back(cyc + 1);
        exp_q2.push_back(exp2);
        due_q2.push_back(cyc + 2);
        tick();
        req_valid = 1'b0;
    endtask

    // Counts samples with init_busy high, starting at the current sample.
    task automatic wait_clear(input string tag);
        n1 = 0;
        n2 = 0;
        for (int i = 0; i < 100; i++) begin
            if (init_busy1) n1++;
            if (init_busy2) n2++;
            if (!init_busy1 && !init_busy2) break;
            tick();
        end
        check({tag, "_busy_lat1"}, n1, DEPTH);
        check({tag, "_busy_lat2"}, n2, DEPTH);
        check({tag, "_ready"}, {bus1.req_ready, bus2.req_ready}, 2'b11);
        check({tag, "_state"}, {state1, state2}, 2'b11);
    endtask

    task automatic drop_pending();
        while (due_q1.size() > 0 && due_q1[$] > cyc) begin
            void'(due_q1.pop_back());
            void'(exp_q1.pop_back());
        end
        while (due_q2.size() > 0 && due_q2[$] > cyc) begin
            void'(due_q2.pop_back());
            void'(exp_q2.pop_back());
        end
    endtask

    initial begin
        a5_row    = {32{8'hA5}};
        new7_line = {8{16'h1234}};
        old7      = {32{8'h5A}};
        new7      = {2{new7_line}};

        // Reset state
        RST = 1'b1;
        tick();
        mon_en = 1'b1;
        tick();
        RST = 1'b0;
        check("rst_busy", {init_busy1, init_busy2}, 2'b11);
        check("rst_ready", {bus1.req_ready, bus2.req_ready}, 2'b00);
        check("rst_rsp_valid", {bus1.rsp_valid, bus2.rsp_valid}, 2'b00);
        check("rst_rdata_lat1", bus1.rsp_rdata, '0);
        check("rst_rdata_lat2", bus2.rsp_rdata, '0);
        check("rst_state", {state1, state2}, 2'b00);
        wait_clear("init");

        // Cleared array reads zero, back-to-back
        do_read(0, '0, '0);
        do_read(5, '0, '0);
        do_read(31, '0, '0);

        // Full write, then read the next cycle
        do_write(5, '1, {16{8'hA5}});
        do_read(5, a5_row, a5_row);

        // Single-byte enables on way0 and way1
        do_write(3, 32'h0000_0001, {{15{8'h11}}, 8'hFF});
        do_read(3, 256'hFF, 256'hFF);
        do_write(12, 32'h0001_0000, {{15{8'h22}}, 8'h3C});
        do_read(12, 256'h3C << 128, 256'h3C << 128);
        do_write(20, 32'h8001_8001, {8'hEE, {14{8'h77}}, 8'hDD});
        do_read(20, {8'hEE, 112'h0, 8'hDD, 8'hEE, 112'h0, 8'hDD},
                    {8'hEE, 112'h0, 8'hDD, 8'hEE, 112'h0, 8'hDD});

        // All-zero byte enables leave the row untouched
        do_write(5, '0, '0);
        do_read(5, a5_row, a5_row);
        do_read(3, 256'hFF, 256'hFF);

        // Write landing while a read of the same set is in the output stage
        do_write(7, '1, {16{8'h5A}});
`ifdef DATA_ARRAY_FWD_EN
        do_read(7, old7, new7);
`else
        do_read(7, old7, old7);
`endif
        do_write(7, '1, new7_line);
        do_read(7, new7, new7);
        tick();
        tick();

        // Read in flight when clr_req arrives returns pre-clear data
        do_read(5, a5_row, a5_row);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        check("clr_ready", {bus1.req_ready, bus2.req_ready}, 2'b00);
        check("clr_state", {state1, state2}, 2'b00);
        wait_clear("clr");
        do_read(5, '0, '0);
        do_read(7, '0, '0);
        do_read(20, '0, '0);

        // clr_req during CLEAR restarts the sequence
        do_write(9, '1, {16{8'h77}});
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        wait_clear("restart");
        do_read(9, '0, '0);

        // RST while a READ_LAT=2 read is still in flight drops that response
        do_write(9, '1, {16{8'h77}});
        do_read(9, {32{8'h77}}, {32{8'h77}});
        RST = 1'b1;
        drop_pending();
        tick();
        RST = 1'b0;
        check("rst2_rsp_valid_lat2", bus2.rsp_valid, 1'b0);
        wait_clear("rst2");
        do_read(9, '0, '0);
        tick();
        tick();
        tick();

        check("drain_lat1", exp_q1.size(), 0);
        check("drain_lat2", exp_q2.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
